// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
// Defaults match the 100 MHz system clock of the soil-monitoring bot.
package pwm_pkg;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_PRESC_W = 16;
    localparam int F_CLOCK     = 100_000_000;

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Runtime-programmable divider: one-clock tick every prescale_div+1 clocks.
// Reusable replacement for the old fixed 100 MHz to 1 kHz divider.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale_div,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt;
    logic               at_limit;

    // >= lets a lowered divider take effect without waiting for a full wrap.
    assign at_limit = presc_cnt >= prescale_div;
    assign tick     = reset_n & enable & at_limit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
        end else if (!enable || at_limit) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// Multi-channel PWM: shared prescaler and period counter, per-channel
// double-buffered duty compare with selectable output polarity.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter  int NUM_CH  = DEF_NUM_CH,
    parameter  int CNT_W   = DEF_CNT_W,
    parameter  int PRESC_W = DEF_PRESC_W,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale_div,
    input  logic [CNT_W-1:0]   period,
    input  logic               duty_wr,
    input  logic [CH_W-1:0]    duty_ch,
    input  logic [CNT_W-1:0]   duty_value,
    input  logic [NUM_CH-1:0]  polarity,
    output logic [NUM_CH-1:0]  pwm_out,
    output logic               tick_out,
    output logic               period_start
);

    logic             tick;
    logic             wrap;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_act;

    pwm_prescaler #(
        .PRESC_W(PRESC_W)
    ) u_prescaler (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .prescale_div(prescale_div),
        .tick        (tick)
    );

    assign tick_out = tick;
    assign wrap     = tick & (cnt >= period_act);

    // While idle the active copies track the live inputs, so enabling
    // always starts a fresh period with the latest settings.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            period_act   <= '0;
            period_start <= 1'b0;
        end else if (!enable) begin
            cnt          <= '0;
            period_act   <= period;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (wrap) begin
                cnt        <= '0;
                period_act <= period;
            end else if (tick) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] shadow;
        logic [CNT_W-1:0] duty_act;
        logic             pwm_q;

        // A write landing on the wrap edge misses this reload (old shadow
        // is sampled) and applies from the following period.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                shadow   <= '0;
                duty_act <= '0;
                pwm_q    <= 1'b0;
            end else begin
                if (duty_wr && (duty_ch == CH_W'(g))) begin
                    shadow <= duty_value;
                end
                if (!enable || wrap) begin
                    duty_act <= shadow;
                end
                pwm_q <= enable ? ((cnt < duty_act) ^ polarity[g]) : polarity[g];
            end
        end

        assign pwm_out[g] = pwm_q;
    end

endmodule
